// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit mid-period
// and presents bytes with a one-cycle valid pulse or a one-cycle framing-error pulse.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             hist_r;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             rx_frame_err_r;
    logic             rx_busy_r;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Receive FSM with registered data, pulse and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            clk_cnt_r      <= '0;
            bit_idx_r      <= 3'd0;
            shift_r        <= 8'h00;
            rx_data_r      <= 8'h00;
            rx_valid_r     <= 1'b0;
            rx_frame_err_r <= 1'b0;
            rx_busy_r      <= 1'b0;
        end else begin
            rx_valid_r     <= 1'b0;
            rx_frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Only a true high-to-low transition starts a frame
                    if (!sync2_r && hist_r) begin
                        state_r   <= START;
                        clk_cnt_r <= '0;
                        rx_busy_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (clk_cnt_r == HALF_LAST) begin
                        clk_cnt_r <= '0;
                        bit_idx_r <= 3'd0;
                        if (!sync2_r) begin
                            state_r <= DATA;
                        end else begin
                            state_r   <= IDLE;
                            rx_busy_r <= 1'b0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_r == FULL_LAST) begin
                        clk_cnt_r          <= '0;
                        shift_r[bit_idx_r] <= sync2_r;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_r == FULL_LAST) begin
                        clk_cnt_r <= '0;
                        if (sync2_r) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                            state_r    <= IDLE;
                            rx_busy_r  <= 1'b0;
                        end else begin
                            rx_frame_err_r <= 1'b1;
                            state_r        <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until a break ends so it is not read as more frames
                    if (sync2_r) begin
                        state_r   <= IDLE;
                        rx_busy_r <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= '0;
                    rx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_busy      = rx_busy_r;

endmodule
